// File: rtl/stopwatch_display.sv
// -----------------------------------------------------------------------------
// stopwatch_display
//
// Turns a binary MM:SS stopwatch value into a four-digit multiplexed
// seven-segment display with a colon dot between minutes and seconds.
// A small FSM converts the value to BCD with the shift-add-3 (double-dabble)
// method whenever the inputs change. A free-running scan counter then walks
// the digit enables.
//
// Parameters
//   SCAN_DIV    clk cycles each digit stays enabled
//   BLINK_HALF  digit-slot advances per blink half-period (used when PAUSED)
//
// Ports
//   clk_i       system clock, rising edge
//   rst_ni      asynchronous active-low reset
//   minutes_i   binary minutes (values above 99 are shown as 99 with ovf_o)
//   seconds_i   binary seconds, 0-59
//   status_i    00 IDLE, 01 RUNNING, 10 PAUSED (blinks), 11 invalid (blank)
//   seg_o       segments {g,f,e,d,c,b,a}, active-low, registered
//   an_o        digit enables, active-low one-hot, an_o[0] = seconds units
//   dp_n_o      colon dot, active-low, only ever lit on the an_o[2] slot
//   ovf_o       displayed minutes are saturated at 99
//   busy_o      BCD conversion in progress
// -----------------------------------------------------------------------------
module stopwatch_display #(
   parameter int SCAN_DIV   = 50000,
   parameter int BLINK_HALF = 250
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [7:0] minutes_i,
   input  logic [5:0] seconds_i,
   input  logic [1:0] status_i,
   output logic [6:0] seg_o,
   output logic [3:0] an_o,
   output logic       dp_n_o,
   output logic       ovf_o,
   output logic       busy_o
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam int SCAN_W  = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
   localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

   // One double-dabble iteration on {bcd[7:0], bin[7:0]}: adjust both BCD
   // nibbles, then shift everything left by one bit.
   function automatic logic [15:0] dd_step(input logic [15:0] sr);
      logic [15:0] t;
      t = sr;
      if (t[11:8] >= 4'd5) t[11:8] = t[11:8] + 4'd3;
      if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
      return {t[14:0], 1'b0};
   endfunction

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   // ---------------------------------------------------------------- converter
   logic [1:0]  state_q,    state_d;
   logic [13:0] snap_q,     snap_d;
   logic [15:0] min_sr_q,   min_sr_d;
   logic [15:0] sec_sr_q,   sec_sr_d;
   logic [2:0]  bit_cnt_q,  bit_cnt_d;
   logic        ovf_pend_q, ovf_pend_d;
   logic [15:0] bcd_q,      bcd_d;       // {min tens, min units, sec tens, sec units}
   logic        ovf_q,      ovf_d;
   logic        busy_q,     busy_d;

   always_comb begin
      state_d    = state_q;
      snap_d     = snap_q;
      min_sr_d   = min_sr_q;
      sec_sr_d   = sec_sr_q;
      bit_cnt_d  = bit_cnt_q;
      ovf_pend_d = ovf_pend_q;
      bcd_d      = bcd_q;
      ovf_d      = ovf_q;
      busy_d     = busy_q;
      case (state_q)
         ST_IDLE: begin
            // The snapshot holds the raw inputs so a saturated minute value
            // does not retrigger a conversion every cycle.
            if ({minutes_i, seconds_i} != snap_q) begin
               snap_d     = {minutes_i, seconds_i};
               min_sr_d   = {8'd0, (minutes_i > 8'd99) ? 8'd99 : minutes_i};
               sec_sr_d   = {8'd0, 2'b00, seconds_i};
               ovf_pend_d = (minutes_i > 8'd99);
               bit_cnt_d  = 3'd0;
               busy_d     = 1'b1;
               state_d    = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            min_sr_d  = dd_step(min_sr_q);
            sec_sr_d  = dd_step(sec_sr_q);
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = ST_DONE;
         end
         ST_DONE: begin
            // Digits and overflow flag change together so the display never
            // shows a half-updated value.
            bcd_d   = {min_sr_q[15:8], sec_sr_q[15:8]};
            ovf_d   = ovf_pend_q;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         snap_q     <= '0;
         min_sr_q   <= '0;
         sec_sr_q   <= '0;
         bit_cnt_q  <= '0;
         ovf_pend_q <= 1'b0;
         bcd_q      <= '0;
         ovf_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         snap_q     <= snap_d;
         min_sr_q   <= min_sr_d;
         sec_sr_q   <= sec_sr_d;
         bit_cnt_q  <= bit_cnt_d;
         ovf_pend_q <= ovf_pend_d;
         bcd_q      <= bcd_d;
         ovf_q      <= ovf_d;
         busy_q     <= busy_d;
      end
   end

   // ----------------------------------------------------------- scan / blink
   logic [SCAN_W-1:0]  scan_cnt_q;
   logic [BLINK_W-1:0] blink_cnt_q;
   logic               blink_on_q;
   logic [1:0]         digit_idx_q;
   logic               scan_wrap;

   assign scan_wrap = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         scan_cnt_q  <= '0;
         blink_cnt_q <= '0;
         blink_on_q  <= 1'b1;
         digit_idx_q <= 2'd0;
      end else begin
         if (scan_wrap) begin
            scan_cnt_q  <= '0;
            digit_idx_q <= digit_idx_q + 2'd1;
            if (blink_cnt_q == BLINK_W'(BLINK_HALF - 1)) begin
               blink_cnt_q <= '0;
               blink_on_q  <= ~blink_on_q;
            end else begin
               blink_cnt_q <= blink_cnt_q + 1'b1;
            end
         end else begin
            scan_cnt_q <= scan_cnt_q + 1'b1;
         end
      end
   end

   // --------------------------------------------------------- output stage
   logic [3:0] digit_sel;
   logic       visible;
   logic [6:0] seg_q, seg_d;
   logic [3:0] an_q,  an_d;
   logic       dp_n_q, dp_n_d;

   always_comb begin
      case (digit_idx_q)
         2'd0:    digit_sel = bcd_q[3:0];
         2'd1:    digit_sel = bcd_q[7:4];
         2'd2:    digit_sel = bcd_q[11:8];
         default: digit_sel = bcd_q[15:12];
      endcase
      // Status is used unregistered here; the output register below gives
      // it the one-cycle update without touching the converter.
      visible = (status_i != 2'b11) && !((status_i == 2'b10) && !blink_on_q);
      seg_d   = visible ? seg_decode(digit_sel) : 7'h7F;
      an_d    = ~(4'b0001 << digit_idx_q);
      dp_n_d  = !(visible && (digit_idx_q == 2'd2));
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         seg_q  <= 7'b1000000;
         an_q   <= 4'b1110;
         dp_n_q <= 1'b1;
      end else begin
         seg_q  <= seg_d;
         an_q   <= an_d;
         dp_n_q <= dp_n_d;
      end
   end

   assign seg_o  = seg_q;
   assign an_o   = an_q;
   assign dp_n_o = dp_n_q;
   assign ovf_o  = ovf_q;
   assign busy_o = busy_q;

endmodule

// File: tb/tb_stopwatch_display.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_display
//
// Stimulus pushes one expected conversion (raw value and the cycle at which it
// must complete) into a queue whenever it changes the inputs in a way that
// must start a conversion. A monitor, sampling on the falling clock edge,
// pops an entry whenever busy drops and compares every cycle the scanned
// display against a time-based model of slot, blink phase and displayed digits.
// -----------------------------------------------------------------------------
module tb_stopwatch_display;

   localparam int SCAN_DIV   = 4;
   localparam int BLINK_HALF = 2;

   logic       clk     = 1'b0;
   logic       rst_n   = 1'b0;
   logic [7:0] minutes = 8'd0;
   logic [5:0] seconds = 6'd0;
   logic [1:0] status  = 2'b00;
   logic [6:0] seg;
   logic [3:0] an;
   logic       dp_n;
   logic       ovf;
   logic       busy;

   stopwatch_display #(
      .SCAN_DIV   (SCAN_DIV),
      .BLINK_HALF (BLINK_HALF)
   ) dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .minutes_i (minutes),
      .seconds_i (seconds),
      .status_i  (status),
      .seg_o     (seg),
      .an_o      (an),
      .dp_n_o    (dp_n),
      .ovf_o     (ovf),
      .busy_o    (busy)
   );

   always #5 clk = ~clk;

   // Clock edges since reset release.
   int edge_cnt = 0;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) edge_cnt <= 0;
      else        edge_cnt <= edge_cnt + 1;
   end

   typedef struct {
      int m;
      int s;
      int done_k;
   } conv_t;

   conv_t exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got 0x%0h, required 0x%0h", name, edge_cnt, act, req);
      end
   endtask

   function automatic int seg_code(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'h7F;
      endcase
   endfunction

   // ------------------------------------------------------------- monitor
   int disp_m = 0, disp_s = 0, ovf_exp = 0;
   int prev_busy = 0, busy_run = 0, prev_status = 0;

   always @(negedge clk) begin
      int k, slot, digit;
      bit phase_on, visible;
      conv_t item;
      if (!rst_n) begin
         check("rst_an", int'(an), 4'b1110);
         check("rst_seg", int'(seg), 7'b1000000);
         check("rst_dp_n", int'(dp_n), 1);
         check("rst_ovf", int'(ovf), 0);
         check("rst_busy", int'(busy), 0);
         exp_q.delete();
         disp_m = 0; disp_s = 0; ovf_exp = 0;
         prev_busy = 0; busy_run = 0;
      end else begin
         k = edge_cnt;
         if (k == 0) begin
            check("rel_an", int'(an), 4'b1110);
            check("rel_seg", int'(seg), 7'b1000000);
            check("rel_busy", int'(busy), 0);
         end else begin
            // Output after edge k reflects counters as they were after edge k-1.
            slot     = ((k - 1) / SCAN_DIV) % 4;
            phase_on = (((k - 1) / (SCAN_DIV * BLINK_HALF)) % 2) == 0;
            visible  = (prev_status != 3) && !((prev_status == 2) && !phase_on);
            case (slot)
               0: digit = disp_s % 10;
               1: digit = disp_s / 10;
               2: digit = disp_m % 10;
               default: digit = disp_m / 10;
            endcase
            check("an", int'(an), (~(1 << slot)) & 15);
            check("seg", int'(seg), visible ? seg_code(digit) : 7'h7F);
            check("dp_n", int'(dp_n), (visible && slot == 2) ? 0 : 1);
         end
         if (busy) busy_run++;
         if (prev_busy != 0 && !busy) begin
            if (exp_q.size() == 0) begin
               check("unexpected_conv", 1, 0);
            end else begin
               item = exp_q.pop_front();
               check("done_cycle", k, item.done_k);
               check("busy_len", busy_run, 9);
               disp_m  = (item.m > 99) ? 99 : item.m;
               disp_s  = item.s;
               ovf_exp = (item.m > 99) ? 1 : 0;
               $display("conv in=%0d:%0d shown=%02d:%02d ovf=%0d done@%0d",
                        item.m, item.s, disp_m, disp_s, ovf_exp, k);
            end
            busy_run = 0;
         end else if (exp_q.size() > 0 && k > exp_q[0].done_k) begin
            check("conv_timeout", k, exp_q[0].done_k);
            void'(exp_q.pop_front());
         end
         check("ovf", int'(ovf), ovf_exp);
         prev_busy = int'(busy);
      end
      prev_status = int'(status);
   end

   // ------------------------------------------------------------ stimulus
   int cap_m = 0, cap_s = 0, last_done = 0;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Caller guarantees the converter is idle; a change from the last captured
   // value starts a conversion finishing ten edges later.
   task automatic set_inputs(input int m, input int s);
      minutes = 8'(m);
      seconds = 6'(s);
      if (m != cap_m || s != cap_s) begin
         last_done = edge_cnt + 10;
         exp_q.push_back('{m, s, last_done});
         cap_m = m;
         cap_s = s;
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick(1);
      check("idle_wait", exp_q.size(), 0);
      tick(1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tick(3);
      rst_n = 1'b1;
      tick(40);                          // idle display 00:00, scan + colon

      set_inputs(12, 34); wait_idle(); tick(20);

      set_inputs(0, 59);  wait_idle(); tick(16);
      set_inputs(1, 0);   wait_idle(); tick(16);

      set_inputs(150, 7); wait_idle(); tick(16);
      set_inputs(5, 7);   wait_idle(); tick(16);

      status = 2'b10; tick(48);          // paused: blink
      status = 2'b01; tick(20);
      status = 2'b11; tick(12);          // invalid: blank
      status = 2'b01; tick(8);

      // Changes during the conversion are ignored, latest value wins after.
      set_inputs(23, 45);
      tick(3); minutes = 8'd40; seconds = 6'd1;
      tick(2); minutes = 8'd41; seconds = 6'd2;
      exp_q.push_back('{41, 2, last_done + 10});
      cap_m = 41; cap_s = 2;
      wait_idle(); tick(16);

      // Reset in the middle of a conversion, nonzero inputs at release.
      set_inputs(7, 8);
      tick(4);
      rst_n = 1'b0;
      tick(3);
      rst_n = 1'b1;
      cap_m = 0; cap_s = 0;
      set_inputs(7, 8);
      wait_idle(); tick(16);

      for (int i = 0; i < 15; i++) begin
         int m, s;
         m = ($urandom_range(0, 3) == 0) ? int'($urandom_range(100, 255)) : int'($urandom_range(0, 99));
         s = int'($urandom_range(0, 59));
         status = 2'($urandom_range(0, 3));
         set_inputs(m, s);
         wait_idle();
         tick(int'($urandom_range(0, 20)));
      end

      status = 2'b01;
      wait_idle();
      tick(20);
      check("queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/stopwatch_display.md
STOPWATCH_DISPLAY -- requirements
Module: stopwatch_display

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clk cycles per digit scan slot (sim: 4).
REQ-002 Parameter BLINK_HALF, default 250, scan-counter wraps per blink half-period (sim: 2).
REQ-003 clk  input  1  system clock, all logic rising-edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 minutes  input  8  binary minutes from stopwatch_top.
REQ-006 seconds  input  6  binary seconds from stopwatch_top, 0-59.
REQ-007 status  input  2  00 IDLE, 01 RUNNING, 10 PAUSED, 11 invalid.
REQ-008 seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-009 an  output  4  digit enables, active-low one-hot, an[0] = seconds units.
REQ-010 dp_n  output  1  colon/decimal point, active-low, lit only on an[2] slot.
REQ-011 ovf  output  1  high while displayed minutes value saturated (minutes > 99).
REQ-012 busy  output  1  high while BCD conversion in progress.

Function
REQ-013 Conversion FSM states: IDLE, SHIFT, DONE.
REQ-014 IDLE: when {minutes,seconds} differs from snapshot register, capture inputs into snapshot and shift register, go SHIFT; busy=1 from next cycle.
REQ-015 Minutes > 99 captured as 99 with ovf set; ovf cleared on next capture of minutes <= 99.
REQ-016 SHIFT: shift-add-3 (double-dabble) on minutes (8 bits) and zero-extended seconds (8 bits) in parallel, exactly 8 cycles.
REQ-017 DONE: one cycle; load 4 BCD display registers atomically, busy=0, return IDLE.
REQ-018 Latency: input change at edge N -> capture at N+1, BCD registers updated at edge N+10.
REQ-019 Input changes during SHIFT/DONE ignored; compared again on return to IDLE (latest value wins, no queue).
REQ-020 Scan counter counts 0..SCAN_DIV-1; on wrap, digit index advances 0->1->2->3->0.
REQ-021 an/seg/dp_n registered from digit index and BCD registers; 1-cycle update after index change.
REQ-022 Decode 0-9 standard seven-segment; codes 10-15 unreachable, drive blank (7'h7F).
REQ-023 Blink counter counts scan-counter wraps; toggles blink phase every BLINK_HALF wraps.
REQ-024 status RUNNING or IDLE: digits steady; PAUSED: seg=7'h7F and dp_n=1 during blink-off phase, an still scans.
REQ-025 status 11: seg=7'h7F, dp_n=1 all slots.
REQ-026 Leading zeros always displayed (00:00 format).
REQ-027 Status change takes effect on next registered output update; never restarts conversion.

Reset
REQ-028 rst_n low asynchronously: FSM IDLE, snapshot=0, BCD registers=0, scan/blink counters=0, digit index=0, blink phase on.
REQ-029 Reset outputs: an=4'b1110, seg=7'b1000000 ('0'), dp_n=1, ovf=0, busy=0.
REQ-030 Release of rst_n with inputs nonzero triggers conversion per REQ-014 on first clock.
REQ-031 rst_n asserted mid-SHIFT aborts conversion; no partial BCD load.

Verification
REQ-032 Reset, inputs 0, SCAN_DIV=4: an cycles 1110,1101,1011,0111 every 4 clocks; all digits '0'; dp_n=0 only with an=1011.
REQ-033 minutes=12, seconds=34 at edge N: busy high N+1..N+9; BCD registers = 1,2,3,4 at N+10; seg per slot = '4','3','2','1'.
REQ-034 seconds 59->0, minutes 0->1 same edge: display 00:59 -> 01:00, no intermediate value shown.
REQ-035 minutes=150: display 99:ss, ovf=1; then minutes=5: display 05:ss, ovf=0.
REQ-036 status=10, BLINK_HALF=2: seg=7'h7F for 8 clocks, digits for 8 clocks, alternating; status=01 -> steady.
REQ-037 rst_n pulse during SHIFT: outputs return to REQ-029 values immediately; new conversion after release.
